// File: rtl/lockstep_pkg.sv
// Shared types and defaults for the done/result lockstep checker.
package lockstep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_DONE_COUNT = 7;
  localparam int DEFAULT_TIMEOUT    = 64;
  localparam int DEFAULT_MISS_W     = 8;

endpackage

// File: rtl/lockstep_model.sv
// Golden replica of the reference counter: count from 0, +1 per advance,
// done once count reaches DONE_COUNT.
module lockstep_model
  import lockstep_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DONE_COUNT = DEFAULT_DONE_COUNT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] DONE_AT = WIDTH'(DONE_COUNT);

  // Counter: clear restarts a run at 0, advance steps once per compare cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else if (advance)   count <= count + ONE;
  end

  assign done = (count >= DONE_AT);

endmodule

// File: rtl/lockstep_checker.sv
// Lockstep consumer: compares a DUT's done/result against the golden model
// every RUN cycle, then latches pass/fail and first-failure diagnostics.
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DONE_COUNT = DEFAULT_DONE_COUNT,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int MISS_W     = DEFAULT_MISS_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              dut_done,
  input  logic [WIDTH-1:0]  dut_result,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [MISS_W-1:0] mismatch_count,
  output logic [WIDTH-1:0]  first_bad_cycle,
  output logic [WIDTH-1:0]  first_bad_value,
  output logic [WIDTH-1:0]  expected
);

  localparam logic [WIDTH-1:0]  LAST_CYC = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);
  localparam logic [MISS_W-1:0] ONE_M    = MISS_W'(1);

  state_t           state;
  logic [WIDTH-1:0] cyc;
  logic [WIDTH-1:0] exp_count;
  logic             exp_done;
  logic             in_run;
  logic             launch;
  logic             miss;
  logic             any_miss;
  logic             complete;

  assign in_run = (state == ST_RUN);
  // start is only honoured outside RUN; it re-arms the model for a new run.
  assign launch = start && !in_run;

  lockstep_model #(
    .WIDTH      (WIDTH),
    .DONE_COUNT (DONE_COUNT)
  ) u_model (
    .clock   (clock),
    .reset   (reset),
    .clear   (launch),
    .advance (in_run),
    .count   (exp_count),
    .done    (exp_done)
  );

  assign miss     = (dut_result != exp_count) || (dut_done != exp_done);
  // Counter saturates rather than wrapping, so nonzero always means "seen one".
  assign any_miss = miss || (mismatch_count != '0);
  assign complete = dut_done && exp_done;

  // Run-control FSM with registered verdict and diagnostics.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      cyc             <= '0;
      pass            <= 1'b0;
      fail            <= 1'b0;
      timeout         <= 1'b0;
      mismatch_count  <= '0;
      first_bad_cycle <= '0;
      first_bad_value <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          cyc <= cyc + ONE_W;
          if (miss) begin
            if (mismatch_count != '1) mismatch_count <= mismatch_count + ONE_M;
            if (mismatch_count == '0) begin
              first_bad_cycle <= cyc;
              first_bad_value <= dut_result;
            end
          end
          // Completion beats timeout when both land on the same cycle.
          if (complete) begin
            state <= any_miss ? ST_FAIL : ST_PASS;
            pass  <= !any_miss;
            fail  <= any_miss;
          end else if (cyc == LAST_CYC) begin
            state   <= ST_FAIL;
            fail    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            state           <= ST_RUN;
            cyc             <= '0;
            pass            <= 1'b0;
            fail            <= 1'b0;
            timeout         <= 1'b0;
            mismatch_count  <= '0;
            first_bad_cycle <= '0;
            first_bad_value <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = in_run;
  assign expected = exp_count;

endmodule

// File: tb/tb_lockstep_checker.sv
// Bench for lockstep_checker: a behavioural DUT drives done/result, expected
// verdicts go into a scoreboard queue at launch and are popped at run end.
module tb_lockstep_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance a: default parameters; instance b: long timeout for saturation.
  logic        start_a = 0, done_a = 0, busy_a, pass_a, fail_a, tmo_a;
  logic [31:0] res_a = 0, fbc_a, fbv_a, exp_a;
  logic [7:0]  mc_a;
  logic        start_b = 0, done_b = 0, busy_b, pass_b, fail_b, tmo_b;
  logic [31:0] res_b = 0, fbc_b, fbv_b, exp_b;
  logic [7:0]  mc_b;

  lockstep_checker dut_a (
    .clock(clk), .reset(reset), .start(start_a), .dut_done(done_a),
    .dut_result(res_a), .busy(busy_a), .pass(pass_a), .fail(fail_a),
    .timeout(tmo_a), .mismatch_count(mc_a), .first_bad_cycle(fbc_a),
    .first_bad_value(fbv_a), .expected(exp_a)
  );

  lockstep_checker #(.TIMEOUT(300)) dut_b (
    .clock(clk), .reset(reset), .start(start_b), .dut_done(done_b),
    .dut_result(res_b), .busy(busy_b), .pass(pass_b), .fail(fail_b),
    .timeout(tmo_b), .mismatch_count(mc_b), .first_bad_cycle(fbc_b),
    .first_bad_value(fbv_b), .expected(exp_b)
  );

  typedef struct {
    int cycles;
    bit pass, fail, tmo;
    int mc, fbc, fbv;
  } res_t;

  typedef struct {
    int   sel;
    int   mode;
    res_t want;
  } vec_t;

  res_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, req);
    end
  endtask

  // Behavioural DUT: a correct counter (done from 7) with per-mode faults.
  function automatic void stim(input int mode, input int k,
                               output logic [31:0] r, output logic d);
    r = k;
    d = (k >= 7);
    case (mode)
      1: if (k == 3) r = 4;
      2: d = 1'b0;
      3: d = (k >= 5);
      4: begin r = k + 1; d = 1'b0; end
      default: ;
    endcase
  endfunction

  task automatic drive(input int sel, input logic st, input logic [31:0] r, input logic d);
    if (sel == 0) begin start_a = st; res_a = r; done_a = d; end
    else          begin start_b = st; res_b = r; done_b = d; end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  // Launch a run and feed the DUT model until the checker leaves RUN.
  task automatic run_scn(input int sel, input int mode, input int limit,
                         output int cycles, output bit expired);
    logic [31:0] r;
    logic        d;
    int          k;
    @(negedge clk);
    drive(sel, 1'b1, 32'd0, 1'b0);
    @(posedge clk); #1;
    k = 0;
    expired = 1'b1;
    while (k < limit) begin
      @(negedge clk);
      stim(mode, k, r, d);
      // mode 5: correct DUT with a stray start mid-run
      drive(sel, (mode == 5) && (k == 2), r, d);
      @(posedge clk); #1;
      if (!busy_of(sel)) begin expired = 1'b0; break; end
      k++;
    end
    cycles = k + 1;
    @(negedge clk);
    drive(sel, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic check_run(input string tag, input int sel, input int cycles, input bit expired);
    res_t w;
    w = sb.pop_front();
    chk({tag, " bound"}, expired, 0);
    chk({tag, " run_cycles"}, cycles, w.cycles);
    if (sel == 0) begin
      chk({tag, " pass"}, pass_a, w.pass);
      chk({tag, " fail"}, fail_a, w.fail);
      chk({tag, " timeout"}, tmo_a, w.tmo);
      chk({tag, " mismatch_count"}, mc_a, w.mc);
      chk({tag, " first_bad_cycle"}, fbc_a, w.fbc);
      chk({tag, " first_bad_value"}, fbv_a, w.fbv);
      chk({tag, " expected"}, exp_a, w.cycles);
    end else begin
      chk({tag, " pass"}, pass_b, w.pass);
      chk({tag, " fail"}, fail_b, w.fail);
      chk({tag, " timeout"}, tmo_b, w.tmo);
      chk({tag, " mismatch_count"}, mc_b, w.mc);
      chk({tag, " first_bad_cycle"}, fbc_b, w.fbc);
      chk({tag, " first_bad_value"}, fbv_b, w.fbv);
      chk({tag, " expected"}, exp_b, w.cycles);
    end
  endtask

  initial begin
    vec_t        vecs[6];
    int          cycles;
    bit          expired;
    logic [31:0] r;
    logic        d;

    //           sel mode  cycles pass fail tmo  mc   fbc fbv
    vecs[0] = '{0, 0, '{  8, 1, 0, 0,   0,  0,  0}};  // clean run
    vecs[1] = '{0, 1, '{  8, 0, 1, 0,   1,  3,  4}};  // bad result at 3
    vecs[2] = '{0, 2, '{ 64, 0, 1, 1,  57,  7,  7}};  // done stuck low
    vecs[3] = '{0, 3, '{  8, 0, 1, 0,   2,  5,  5}};  // early done at 5
    vecs[4] = '{0, 5, '{  8, 1, 0, 0,   0,  0,  0}};  // start ignored in RUN
    vecs[5] = '{1, 4, '{300, 0, 1, 1, 255,  0,  1}};  // saturating counter

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy_a, 0);
    chk("reset pass", pass_a, 0);
    chk("reset fail", fail_a, 0);
    chk("reset timeout", tmo_a, 0);
    chk("reset mismatch_count", mc_a, 0);
    chk("reset first_bad_cycle", fbc_a, 0);
    chk("reset expected", exp_a, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle busy", busy_a, 0);

    foreach (vecs[i]) begin
      sb.push_back(vecs[i].want);
      run_scn(vecs[i].sel, vecs[i].mode, vecs[i].want.cycles + 5, cycles, expired);
      check_run($sformatf("vec%0d", i), vecs[i].sel, cycles, expired);
    end

    // Reset mid-run with start held high: reset must win.
    @(negedge clk);
    drive(0, 1'b1, 32'd0, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      stim(1, k, r, d);
      drive(0, 1'b0, r, d);
      @(posedge clk); #1;
    end
    chk("midrun busy before reset", busy_a, 1);
    chk("midrun mismatch before reset", mc_a, 1);
    @(negedge clk);
    stim(1, 4, r, d);
    drive(0, 1'b1, r, d);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst+start busy", busy_a, 0);
    chk("rst+start mismatch_count", mc_a, 0);
    chk("rst+start first_bad_cycle", fbc_a, 0);
    chk("rst+start first_bad_value", fbv_a, 0);
    chk("rst+start expected", exp_a, 0);
    chk("rst+start fail", fail_a, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("post-reset idle busy", busy_a, 0);

    sb.push_back(vecs[0].want);
    run_scn(0, 0, 13, cycles, expired);
    check_run("after reset", 0, cycles, expired);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
